io_bus_master: RTL

Bus initiator that drives the memory-mapped I/O register port (addr/data/wen/ren/ben with ack) from a single CPU-side load/store request channel. It sits between the CPU memory stage and the I/O register controller. It converts byte, halfword and word accesses into byte-enabled, lane-replicated bus cycles and holds each strobe until ack. It captures and extends read data, and reports misaligned or timed-out accesses as errors.

---
 rtl/io_bus_master.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/io_bus_master.sv
// CPU load/store to memory-mapped I/O bus initiator: lane-replicated, byte-enabled
// bus cycles held until ack, read data extension, misalignment and timeout errors.
module io_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] io_addr,
    output logic [31:0] io_data_o,
    output logic        io_wen,
    output logic        io_ren,
    output logic [3:0]  io_ben,
    input  logic        io_ack,
    input  logic [31:0] io_data_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE, RESP} state_t;

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] count;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic        err_reg;

    logic        misaligned;
    logic [3:0]  ben_dec;
    logic [31:0] wdata_rep;
    logic [31:0] shifted;
    logic [31:0] rdata_ext;

    assign req_ready = (state == IDLE);

    always_comb begin
        misaligned = 1'b0;
        ben_dec    = 4'b1111;
        wdata_rep  = req_wdata;
        case (req_size)
            2'b00: begin
                ben_dec   = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                ben_dec    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{req_wdata[15:0]}};
            end
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Halfword accesses are aligned, so a byte-granular shift also serves them.
    always_comb begin
        shifted   = io_data_i >> {io_addr[1:0], 3'b000};
        rdata_ext = io_data_i;
        case (size_reg)
            2'b00:   rdata_ext = {{24{signed_reg & shifted[7]}}, shifted[7:0]};
            2'b01:   rdata_ext = {{16{signed_reg & shifted[15]}}, shifted[15:0]};
            default: rdata_ext = io_data_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            we_reg     <= 1'b0;
            size_reg   <= 2'b00;
            signed_reg <= 1'b0;
            err_reg    <= 1'b0;
            io_addr    <= '0;
            io_data_o  <= '0;
            io_ben     <= '0;
            io_wen     <= 1'b0;
            io_ren     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            io_addr    <= req_addr;
                            io_ben     <= ben_dec;
                            io_data_o  <= wdata_rep;
                            io_wen     <= req_we;
                            io_ren     <= ~req_we;
                            we_reg     <= req_we;
                            size_reg   <= req_size;
                            signed_reg <= req_signed;
                            count      <= '0;
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (io_ack) begin
                        io_wen  <= 1'b0;
                        io_ren  <= 1'b0;
                        err_reg <= 1'b0;
                        state   <= RELEASE;
                    end else begin
                        count <= count + 16'd1;
                        if (count == LAST_COUNT) begin
                            io_wen  <= 1'b0;
                            io_ren  <= 1'b0;
                            err_reg <= 1'b1;
                            state   <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    // Responder data is valid this cycle, one after its ack.
                    resp_valid <= 1'b1;
                    resp_err   <= err_reg;
                    resp_rdata <= (we_reg || err_reg) ? 32'd0 : rdata_ext;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
